// File: rtl/sram_arb_pkg.sv
// Shared definitions for the frame-SRAM port arbiter and the DDT capture front end.
package sram_arb_pkg;

  localparam int unsigned SRAM_ADDR_W     = 21;
  localparam int unsigned SRAM_DATA_W     = 27;
  localparam int unsigned SOURCE_NUM      = 1024;
  localparam int unsigned FRAME_WORDS_DEF = 1310720;
  localparam int unsigned FIFO_DEPTH_DEF  = 8;
  localparam int unsigned LINE_CNT_W      = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10
  } arb_state_e;

  // Word address of the first pixel of a DDT source line (untruncated).
  function automatic logic [31:0] line_base(input logic [LINE_CNT_W-1:0] line_cnt);
    return 32'(SOURCE_NUM) * {16'd0, line_cnt};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO. Clocked on the falling edge to match
// the rest of the Sys_Clock domain; DEPTH must be a power of two.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  always_comb begin
    do_push  = push && (!full || pop);
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(negedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Time-shares one single-port frame SRAM between the buffered DDT write stream and
// the fixed-latency RGB read stream; reads always win the slot.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = SRAM_ADDR_W,
  parameter int unsigned DATA_W      = SRAM_DATA_W,
  parameter int unsigned FRAME_WORDS = FRAME_WORDS_DEF,
  parameter int unsigned FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
  input  logic                  Sys_Clock,
  input  logic                  Reset,
  input  logic                  Wr_Valid,
  output logic                  Wr_Ready,
  input  logic [DATA_W-1:0]     Wr_Data,
  input  logic                  Wr_Line_Start,
  input  logic [LINE_CNT_W-1:0] Wr_Line_Cnt,
  input  logic                  Wr_Frame_Start,
  output logic                  Wr_Overflow,
  input  logic                  Rd_Frame_Start,
  input  logic                  Rd_Req,
  output logic                  Rd_Valid,
  output logic [DATA_W-1:0]     Rd_Data,
  output logic [ADDR_W-1:0]     SRAM_Addr,
  output logic                  SRAM_CE_n,
  output logic                  SRAM_WE_n,
  output logic                  SRAM_Oe,
  output logic [DATA_W-1:0]     SRAM_Dout,
  input  logic [DATA_W-1:0]     SRAM_Din
);

  localparam int unsigned ENTRY_W = ADDR_W + DATA_W;
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);

  arb_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic                wr_ready_q, wr_ready_d;
  logic                ovf_q, ovf_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                ce_n_q, ce_n_d;
  logic                we_n_q, we_n_d;
  logic                oe_q, oe_d;
  logic                rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;

  logic                accept_c, drop_c, pop_c;
  logic [ADDR_W-1:0]   push_addr_c, rd_addr_c;
  logic [ENTRY_W-1:0]  fifo_head;
  logic [ADDR_W-1:0]   head_addr;
  logic [DATA_W-1:0]   head_data;
  logic                fifo_full, fifo_empty;
  logic [CNT_W-1:0]    fifo_count, level_d;

  assign head_addr = fifo_head[ENTRY_W-1:DATA_W];
  assign head_data = fifo_head[DATA_W-1:0];

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (Sys_Clock),
    .rst_n     (Reset),
    .push      (accept_c),
    .push_data ({push_addr_c, Wr_Data}),
    .pop       (pop_c),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Write side: address generation, ready and sticky overflow.
  always_comb begin
    accept_c    = Wr_Valid && wr_ready_q && !fifo_full;
    drop_c      = Wr_Valid && !accept_c;
    push_addr_c = Wr_Line_Start ? ADDR_W'(line_base(Wr_Line_Cnt)) : wr_addr_q + ADDR_W'(1);
    wr_addr_d   = accept_c ? push_addr_c : wr_addr_q;
    level_d     = fifo_count + CNT_W'(accept_c) - CNT_W'(pop_c);
    wr_ready_d  = (level_d != CNT_W'(FIFO_DEPTH));
    ovf_d       = ovf_q;
    if (Wr_Frame_Start) ovf_d = 1'b0;
    if (drop_c)         ovf_d = 1'b1;
  end

  // Read address: a frame start in the same cycle as a request reads word 0.
  always_comb begin
    rd_addr_c = Rd_Frame_Start ? '0 : rd_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    if (Rd_Req) begin
      rd_cnt_d = (rd_addr_c == ADDR_W'(FRAME_WORDS - 1)) ? '0 : rd_addr_c + ADDR_W'(1);
    end else if (Rd_Frame_Start) begin
      rd_cnt_d = '0;
    end
  end

  // Slot selection and pin values for the state being entered.
  always_comb begin
    state_d = ST_IDLE;
    if (Rd_Req)           state_d = ST_RD;
    else if (!fifo_empty) state_d = ST_WR;
    pop_c  = (state_d == ST_WR);

    ce_n_d = 1'b1;
    we_n_d = 1'b1;
    oe_d   = 1'b0;
    addr_d = addr_q;
    dout_d = dout_q;
    case (state_d)
      ST_RD: begin
        ce_n_d = 1'b0;
        addr_d = rd_addr_c;
      end
      ST_WR: begin
        ce_n_d = 1'b0;
        we_n_d = 1'b0;
        oe_d   = 1'b1;
        addr_d = head_addr;
        dout_d = head_data;
      end
      default: ;
    endcase

    rd_valid_d = (state_q == ST_RD);
    rd_data_d  = (state_q == ST_RD) ? SRAM_Din : rd_data_q;
  end

  always_ff @(negedge Sys_Clock or negedge Reset) begin
    if (!Reset) begin
      state_q    <= ST_IDLE;
      wr_addr_q  <= '0;
      rd_cnt_q   <= '0;
      wr_ready_q <= 1'b0;
      ovf_q      <= 1'b0;
      addr_q     <= '0;
      dout_q     <= '0;
      ce_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      oe_q       <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_addr_q  <= wr_addr_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_ready_q <= wr_ready_d;
      ovf_q      <= ovf_d;
      addr_q     <= addr_d;
      dout_q     <= dout_d;
      ce_n_q     <= ce_n_d;
      we_n_q     <= we_n_d;
      oe_q       <= oe_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign Wr_Ready    = wr_ready_q;
  assign Wr_Overflow = ovf_q;
  assign Rd_Valid    = rd_valid_q;
  assign Rd_Data     = rd_data_q;
  assign SRAM_Addr   = addr_q;
  assign SRAM_CE_n   = ce_n_q;
  assign SRAM_WE_n   = we_n_q;
  assign SRAM_Oe     = oe_q;
  assign SRAM_Dout   = dout_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter: a transaction-level model queues the
// expected pin/status picture per cycle, and a monitor compares it on each rising edge.
module tb_sram_port_arbiter;

  localparam int unsigned AW = 21;
  localparam int unsigned DW = 27;
  localparam int unsigned FW = 100;
  localparam int unsigned DEPTH = 8;

  logic          clk;
  logic          Reset;
  logic          Wr_Valid, Wr_Ready, Wr_Line_Start, Wr_Frame_Start, Wr_Overflow;
  logic [DW-1:0] Wr_Data;
  logic [15:0]   Wr_Line_Cnt;
  logic          Rd_Frame_Start, Rd_Req, Rd_Valid;
  logic [DW-1:0] Rd_Data;
  logic [AW-1:0] SRAM_Addr;
  logic          SRAM_CE_n, SRAM_WE_n, SRAM_Oe;
  logic [DW-1:0] SRAM_Dout, SRAM_Din;

  sram_port_arbiter #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .FRAME_WORDS (FW),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .Sys_Clock      (clk),
    .Reset          (Reset),
    .Wr_Valid       (Wr_Valid),
    .Wr_Ready       (Wr_Ready),
    .Wr_Data        (Wr_Data),
    .Wr_Line_Start  (Wr_Line_Start),
    .Wr_Line_Cnt    (Wr_Line_Cnt),
    .Wr_Frame_Start (Wr_Frame_Start),
    .Wr_Overflow    (Wr_Overflow),
    .Rd_Frame_Start (Rd_Frame_Start),
    .Rd_Req         (Rd_Req),
    .Rd_Valid       (Rd_Valid),
    .Rd_Data        (Rd_Data),
    .SRAM_Addr      (SRAM_Addr),
    .SRAM_CE_n      (SRAM_CE_n),
    .SRAM_WE_n      (SRAM_WE_n),
    .SRAM_Oe        (SRAM_Oe),
    .SRAM_Dout      (SRAM_Dout),
    .SRAM_Din       (SRAM_Din)
  );

  function automatic logic [DW-1:0] sram_word(input logic [AW-1:0] a);
    return {~a[5:0], a};
  endfunction

  assign SRAM_Din = sram_word(SRAM_Addr);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit            ce_n, we_n, oe;
    logic [AW-1:0] addr;
    logic [DW-1:0] dout;
    bit            rd_valid;
    logic [DW-1:0] rd_data;
    bit            ready, ovf;
  } exp_t;

  exp_t                 exp_q[$];
  logic [AW+DW-1:0]     mq[$];
  bit                   mon_en;
  int                   n_cmp, n_err;

  bit            m_ready, m_ovf, m_prev_rd;
  logic [AW-1:0] m_last_wa, m_rd_cnt, m_pin_addr, m_prev_addr;
  logic [DW-1:0] m_pin_dout, m_rd_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ready = 0; m_ovf = 0; m_prev_rd = 0;
    m_last_wa = '0; m_rd_cnt = '0; m_pin_addr = '0; m_prev_addr = '0;
    m_pin_dout = '0; m_rd_data = '0;
  endtask

  // Apply one cycle of inputs and queue what the pins must show after the next edge.
  task automatic drive_cycle(input bit wv, input logic [DW-1:0] wd, input bit ls,
                             input logic [15:0] lc, input bit wfs, input bit rfs, input bit rr);
    exp_t             e;
    logic [AW-1:0]    a;
    logic [31:0]      base;
    logic [AW+DW-1:0] ent;
    bit               drop;
    Wr_Valid = wv; Wr_Data = wd; Wr_Line_Start = ls; Wr_Line_Cnt = lc;
    Wr_Frame_Start = wfs; Rd_Frame_Start = rfs; Rd_Req = rr;

    e.rd_valid = m_prev_rd;
    if (m_prev_rd) m_rd_data = sram_word(m_prev_addr);
    e.rd_data = m_rd_data;
    m_prev_rd = 0;

    e.ce_n = 1; e.we_n = 1; e.oe = 0;
    if (rr) begin
      a = rfs ? '0 : m_rd_cnt;
      m_rd_cnt = (a == AW'(FW - 1)) ? '0 : a + 1'b1;
      e.ce_n = 0;
      m_pin_addr = a;
      m_prev_rd = 1;
      m_prev_addr = a;
    end else begin
      if (rfs) m_rd_cnt = '0;
      if (mq.size() > 0) begin
        ent = mq.pop_front();
        e.ce_n = 0; e.we_n = 0; e.oe = 1;
        m_pin_addr = ent[AW+DW-1:DW];
        m_pin_dout = ent[DW-1:0];
      end
    end
    e.addr = m_pin_addr;
    e.dout = m_pin_dout;

    drop = wv && !m_ready;
    if (wv && m_ready) begin
      if (ls) begin
        base = 32'(lc) * 32'd1024;
        a = base[AW-1:0];
      end else begin
        a = m_last_wa + 1'b1;
      end
      m_last_wa = a;
      mq.push_back({a, wd});
    end
    if (wfs)  m_ovf = 0;
    if (drop) m_ovf = 1;
    m_ready = (mq.size() < DEPTH);
    e.ready = m_ready;
    e.ovf   = m_ovf;

    exp_q.push_back(e);
    mon_en = 1;
  endtask

  task automatic step(input bit wv, input logic [DW-1:0] wd, input bit ls,
                      input logic [15:0] lc, input bit wfs, input bit rfs, input bit rr);
    @(posedge clk);
    #2;
    drive_cycle(wv, wd, ls, lc, wfs, rfs, rr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, '0, 0, 0, 0);
  endtask

  task automatic check_reset_values();
    chk("rst_ce_n",  64'(SRAM_CE_n),   64'd1);
    chk("rst_we_n",  64'(SRAM_WE_n),   64'd1);
    chk("rst_oe",    64'(SRAM_Oe),     64'd0);
    chk("rst_addr",  64'(SRAM_Addr),   64'd0);
    chk("rst_dout",  64'(SRAM_Dout),   64'd0);
    chk("rst_rdv",   64'(Rd_Valid),    64'd0);
    chk("rst_rdata", 64'(Rd_Data),     64'd0);
    chk("rst_ovf",   64'(Wr_Overflow), 64'd0);
    chk("rst_ready", 64'(Wr_Ready),    64'd0);
  endtask

  always @(posedge clk) begin : monitor
    exp_t e;
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        chk("scoreboard_underflow", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("ce_n",     64'(SRAM_CE_n),   64'(e.ce_n));
        chk("we_n",     64'(SRAM_WE_n),   64'(e.we_n));
        chk("oe",       64'(SRAM_Oe),     64'(e.oe));
        chk("addr",     64'(SRAM_Addr),   64'(e.addr));
        chk("dout",     64'(SRAM_Dout),   64'(e.dout));
        chk("rd_valid", 64'(Rd_Valid),    64'(e.rd_valid));
        chk("rd_data",  64'(Rd_Data),     64'(e.rd_data));
        chk("wr_ready", 64'(Wr_Ready),    64'(e.ready));
        chk("overflow", 64'(Wr_Overflow), 64'(e.ovf));
      end
    end
  end

  initial begin
    n_cmp = 0; n_err = 0; mon_en = 0;
    Wr_Valid = 0; Wr_Data = '0; Wr_Line_Start = 0; Wr_Line_Cnt = '0;
    Wr_Frame_Start = 0; Rd_Frame_Start = 0; Rd_Req = 0;
    model_reset();
    Reset = 1;
    #3 Reset = 0;
    #1 check_reset_values();
    repeat (2) @(posedge clk);
    #2 Reset = 1;
    drive_cycle(0, '0, 0, '0, 0, 0, 0);

    // Three pixels of line 2: writes land at 2048..2050.
    step(1, 27'h0000001, 1, 16'd2, 0, 0, 0);
    step(1, 27'h0000002, 0, 16'd0, 0, 0, 0);
    step(1, 27'h0000003, 0, 16'd0, 0, 0, 0);
    idle(5);

    // Four reads from a fresh frame.
    step(0, '0, 0, '0, 0, 1, 1);
    for (int i = 0; i < 3; i++) step(0, '0, 0, '0, 0, 0, 1);
    idle(3);

    // Priority: five pixels queued behind ten read slots.
    for (int i = 0; i < 10; i++)
      step(i < 5, 27'(32'h100 + i), i == 0, 16'd7, 0, 0, 1);
    idle(8);

    // Overflow: nine pixels while reads starve the write slot.
    for (int i = 0; i < 9; i++)
      step(1, 27'(32'h200 + i), i == 0, 16'd9, 0, 0, 1);
    step(0, '0, 0, '0, 0, 0, 1);
    idle(10);
    step(0, '0, 0, '0, 1, 0, 0);
    idle(2);

    // Read counter to 77, then a frame start coinciding with a request.
    step(0, '0, 0, '0, 0, 1, 0);
    for (int i = 0; i < 77; i++) step(0, '0, 0, '0, 0, 0, 1);
    idle(1);
    step(0, '0, 0, '0, 0, 1, 1);
    step(0, '0, 0, '0, 0, 0, 1);
    // Run across the frame wrap point.
    for (int i = 0; i < 105; i++) step(0, '0, 0, '0, 0, 0, 1);
    idle(3);

    // Randomised traffic.
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 9) < 6, 27'($urandom), $urandom_range(0, 9) == 0,
           16'($urandom_range(0, 3000)), $urandom_range(0, 19) == 0,
           $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1);
    idle(10);

    // Reset with four queued pixels and a read in flight.
    for (int i = 0; i < 4; i++)
      step(1, 27'(32'h300 + i), i == 0, 16'd4, 0, 0, 1);
    @(posedge clk);
    #2;
    mon_en = 0;
    exp_q.delete();
    Wr_Valid = 0; Wr_Line_Start = 0; Wr_Frame_Start = 0; Rd_Frame_Start = 0; Rd_Req = 0;
    Reset = 0;
    #1 check_reset_values();
    model_reset();
    repeat (2) @(posedge clk);
    #2 Reset = 1;
    drive_cycle(0, '0, 0, '0, 0, 0, 0);
    idle(6);

    @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
